counter_sequencer: RTL

Control sequencer for the 4-bit up/down `counter` block. It owns that counter's `up`, `clk_en` and `rst` inputs and observes its `Q`. It paces counting with a programmable prescaler and runs one-shot, repeating or ping-pong count programs. It sits between the user-facing control registers and the counter datapath; the counter itself is instantiated outside this block.

---
 rtl/counter_seq_pkg.sv | 26 ++
 rtl/tick_gen.sv | 41 ++++
 rtl/counter_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer.
package counter_seq_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned PRE_W_DEF = 8;
  localparam int unsigned MODE_W    = 2;

  // Program modes; the fourth encoding is reserved and runs as a one-shot.
  localparam logic [MODE_W-1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_REPEAT   = 2'b01;
  localparam logic [MODE_W-1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // True in the states where a program owns the counter.
  function automatic logic is_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_RUN_UP) || (s == ST_RUN_DOWN);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable prescaler: counts down from the reload value and flags a tick at zero.
module tick_gen #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] reload_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // Next prescaler value: explicit load wins, otherwise count down and wrap to reload.
  always_comb begin
    pre_d = pre_q;
    if (load_i) begin
      pre_d = reload_i;
    end else if (en_i) begin
      if (pre_q == '0) begin
        pre_d = reload_i;
      end else begin
        pre_d = pre_q - PRE_W'(1);
      end
    end
  end

  // Prescaler register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick_o = (pre_q == '0);

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer driving an external up/down counter through one-shot, repeat and ping-pong programs.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [PRE_W-1:0] rate,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [PRE_W-1:0]   rate_q, rate_d;
  // Set after the first tick spent at hi in repeat mode; the second tick clears.
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;

  logic               pre_load;
  logic               pre_en;
  logic               tick;

  tick_gen #(
    .PRE_W (PRE_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (pre_load),
    .en_i     (pre_en),
    .reload_i (rate_q),
    .tick_o   (tick)
  );

  // Next-state, program latch and counter-control decode.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    rate_d   = rate_q;
    wrap_d   = wrap_q;
    err_d    = 1'b0;
    pre_load = 1'b0;
    pre_en   = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((mode == MODE_PINGPONG) && (lo > hi)) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mode;
            lo_d    = lo;
            hi_d    = hi;
            rate_d  = rate;
            state_d = ST_CLEAR;
          end
        end
      end

      ST_CLEAR: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          cnt_clr  = 1'b1;
          pre_load = 1'b1;
          wrap_d   = 1'b0;
          state_d  = ST_RUN_UP;
        end
      end

      ST_RUN_UP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          pre_en = 1'b1;
          if (tick) begin
            if (cnt_q != hi_q) begin
              cnt_en = 1'b1;
            end else begin
              case (mode_q)
                MODE_REPEAT: begin
                  if (wrap_q) begin
                    cnt_clr = 1'b1;
                    wrap_d  = 1'b0;
                  end else begin
                    wrap_d  = 1'b1;
                  end
                end
                MODE_PINGPONG: state_d = ST_RUN_DOWN;
                default:       state_d = ST_DONE;
              endcase
            end
          end
        end
      end

      ST_RUN_DOWN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          pre_en = 1'b1;
          if (tick) begin
            if (cnt_q != lo_q) begin
              cnt_en = 1'b1;
            end else begin
              state_d = ST_RUN_UP;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and program registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      lo_q    <= '0;
      hi_q    <= '0;
      rate_q  <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rate_q  <= rate_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign cnt_up = (state_q != ST_RUN_DOWN);
  assign busy   = is_busy(state_q);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;

endmodule
